// File: rtl/caliptra_prim_edn_arb.sv
// rtl/caliptra_prim_edn_arb.sv - round-robin arbiter sharing one EDN req/ack gadget among NumReq consumers
//
// Ports:
//   clk_i, rst_ni         clock and asynchronous active-low reset
//   req_i[NumReq]         per-requester request level
//   ack_o[NumReq]         one-cycle acknowledge to the granted requester
//   gnt_o[NumReq]         one-hot current grant, zero when idle
//   data_o/fips_o/err_o   combinational pass-through of the gadget word and flags
//   discard_o             pulse when a word completes for a requester that dropped out
//   timeout_o             sticky flag, a BUSY wait reached MaxWait
//   edn_req_o/edn_ack_i   handshake to the shared gadget
//   edn_data_i/edn_fips_i/edn_err_i  gadget word and flags
module caliptra_prim_edn_arb #(
    parameter int NumReq   = 2,
    parameter int OutWidth = 32,
    parameter int MaxWait  = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   req_i,
    output logic [NumReq-1:0]   ack_o,
    output logic [NumReq-1:0]   gnt_o,
    output logic [OutWidth-1:0] data_o,
    output logic                fips_o,
    output logic                err_o,
    output logic                discard_o,
    output logic                timeout_o,
    output logic                edn_req_o,
    input  logic                edn_ack_i,
    input  logic [OutWidth-1:0] edn_data_i,
    input  logic                edn_fips_i,
    input  logic                edn_err_i
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumReq - 1);
    localparam logic [CntW-1:0] CntMax   = CntW'(MaxWait);
    localparam logic [IdxW:0]   NumReqEx = (IdxW + 1)'(NumReq);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    state_e          r_state;
    logic [IdxW-1:0] r_rr;
    logic [IdxW-1:0] r_gnt;
    logic [CntW-1:0] r_cnt;
    logic            r_timeout;

    logic            w_busy;
    logic            w_any;
    logic [IdxW-1:0] w_winner;
    logic [IdxW:0]   w_sum;
    logic [IdxW-1:0] w_idx;
    logic [NumReq-1:0] w_onehot;
    logic            w_req_held;

    assign w_busy = (r_state == ST_BUSY);

    // Scan upward from the round-robin pointer, wrapping, and keep the first hit.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_rr;
        w_sum    = '0;
        w_idx    = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_sum = {1'b0, r_rr} + (IdxW + 1)'(i);
            if (w_sum >= NumReqEx) begin
                w_sum = w_sum - NumReqEx;
            end
            w_idx = w_sum[IdxW-1:0];
            if (!w_any && req_i[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_onehot[i] = w_busy && (r_gnt == IdxW'(i));
        end
    end

    assign w_req_held = req_i[r_gnt];

    // The gadget request stays up for the whole BUSY phase even if the
    // granted requester withdraws; its word is then discarded on completion.
    assign edn_req_o = w_busy;
    assign gnt_o     = w_onehot;
    assign ack_o     = (w_busy && edn_ack_i && w_req_held) ? w_onehot : '0;
    assign discard_o = w_busy && edn_ack_i && !w_req_held;
    assign timeout_o = r_timeout;

    assign data_o = edn_data_i;
    assign fips_o = edn_fips_i;
    assign err_o  = edn_err_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_rr      <= '0;
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_winner;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (edn_ack_i) begin
                        r_state <= ST_IDLE;
                        r_rr    <= (r_gnt == LastIdx) ? '0 : r_gnt + 1'b1;
                    end else if (r_cnt != CntMax) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if ((MaxWait != 0) && (r_cnt == CntMax)) begin
                r_timeout <= 1'b1;
            end
        end
    end

endmodule
